seq_cmp: RTL and testbench
==========================

SEQ_CMP -- requirements
Module: seq_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter SLICE, default 2, bits compared per cycle.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous to clk, active-low.
REQ-005 SHALL have port in_valid  input  1  operands a/b presented.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port equal  output  1  a == b.
REQ-012 SHALL have port greater  output  1  a > b.
REQ-013 SHALL have port answer  output  1  a >= b, i.e. greater | equal.
REQ-014 SHALL have port slices_used  output  clog2(NSLICE)+1  slices examined for last result.

Function
REQ-015 SHALL define NSLICE = WIDTH/SLICE, and SHALL error at elaboration if WIDTH % SLICE != 0 or SLICE < 1.
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE, and SHALL drive out_valid = 1 only in DONE.
REQ-018 SHALL, in IDLE with in_valid = 1, register a and b, set slice index idx = NSLICE-1 and move to RUN.
REQ-019 SHALL, in RUN, compare slice idx (bits idx*SLICE+SLICE-1 : idx*SLICE) of the registered operands once per cycle, MSB slice first.
REQ-020 SHALL, when a RUN slice differs, register greater = slice gt, equal = 0, slices_used = NSLICE-idx, and move to DONE (early termination).
REQ-021 SHALL, when slices are equal at idx = 0, register equal = 1, greater = 0, slices_used = NSLICE, and move to DONE; SHALL otherwise decrement idx and stay in RUN.
REQ-022 SHALL assert out_valid exactly k cycles after the accepting edge, where k = slices_used (1..NSLICE).
REQ-023 SHALL, in DONE, hold equal, greater, answer and slices_used stable until out_ready = 1, then move to IDLE on that edge.
REQ-024 SHALL NOT accept new operands in the cycle a result is consumed; the earliest new accept is the following cycle.
REQ-025 SHALL ignore out_ready outside DONE and in_valid outside IDLE.
REQ-026 SHALL keep the result outputs at their last value after leaving DONE, until the next result is registered.

Reset
REQ-027 SHALL, while rst_n = 0 at a clk edge, enter IDLE and clear equal, greater, answer, slices_used, idx and the operand registers to 0, giving in_ready = 1 and out_valid = 0 after reset.
REQ-028 SHALL, on reset during RUN or DONE, discard the operation in flight with no result emitted.

Configuration
REQ-029 SHALL, with macro SEQ_CMP_SIGNED_EN defined, add input port signed_mode (1 bit), sampled with the operands at accept.
REQ-030 SHALL, with SEQ_CMP_SIGNED_EN defined and signed_mode = 1, treat operands as two's complement by inverting the MSB of both operands in the most-significant slice comparison only.
REQ-031 SHALL, without SEQ_CMP_SIGNED_EN, omit signed_mode and compare unsigned only.

Structure
REQ-032 SHALL take the FSM state typedef/encoding and the clog2 helper constant from shared package seq_cmp_pkg.
REQ-033 SHALL instantiate one combinational sub-module cmp_slice (parameter SLICE; inputs a, b; outputs eq, gt) for the per-cycle slice compare.

Verification (WIDTH=16, SLICE=2, NSLICE=8)
REQ-034 SHALL verify: a=0x1234, b=0x1234 -> out_valid 8 cycles after accept; equal=1, greater=0, answer=1, slices_used=8.
REQ-035 SHALL verify: a=0x8000, b=0x7FFF unsigned -> out_valid 1 cycle after accept; greater=1, equal=0, answer=1, slices_used=1.
REQ-036 SHALL verify: a=0x0001, b=0x0002 -> 8 cycles; greater=0, equal=0, answer=0.
REQ-037 SHALL verify: out_ready held low 5 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-038 SHALL verify: rst_n=0 for one edge mid-RUN -> IDLE, in_ready=1, out_valid=0, all results 0, no result emitted.
REQ-039 SHALL verify: with SEQ_CMP_SIGNED_EN defined, signed_mode=1, a=0xFFFF, b=0x0001 -> greater=0, answer=0, slices_used=1; with signed_mode=0 -> greater=1.

Source files
------------

// File: rtl/seq_cmp_pkg.sv
// Shared definitions for the sequential slice comparator: FSM state
// encoding and a constant ceil(log2) helper used to size counters.
package seq_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of bits needed to encode value distinct codes (clog2(1) = 0).
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_cmp_cmp_slice.sv
// Combinational magnitude compare of one SLICE-bit operand slice.
module cmp_slice #(
   parameter int SLICE = 2
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   output logic             eq,
   output logic             gt
);

   // Plain unsigned compare; any sign handling is applied by the caller.
   always_comb begin
      eq = (a == b);
      gt = (a > b);
   end

endmodule

// File: rtl/seq_cmp.sv
// Sequential comparator: compares two WIDTH-bit operands SLICE bits per
// cycle, most-significant slice first, stopping at the first differing
// slice. Optional feature macro SEQ_CMP_SIGNED_EN adds a signed_mode input
// for two's-complement comparison.
module seq_cmp
   import seq_cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 2
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
`ifdef SEQ_CMP_SIGNED_EN
   input  logic                                   signed_mode,
`endif
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [WIDTH-1:0]                       a,
   input  logic [WIDTH-1:0]                       b,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic                                   equal,
   output logic                                   greater,
   output logic                                   answer,
   output logic [clog2(((SLICE > 0) ? WIDTH/SLICE : 1))+1-1:0] slices_used
);

   localparam int NSLICE = (SLICE > 0) ? WIDTH / SLICE : 1;
   localparam int SUW    = clog2(NSLICE) + 1;
   localparam int IDXW   = (clog2(NSLICE) > 0) ? clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

   // Reject geometries where the operand does not split into whole slices.
   if (SLICE < 1) begin : g_bad_slice
      $error("seq_cmp: SLICE must be >= 1");
   end else if ((WIDTH % SLICE) != 0) begin : g_bad_width
      $error("seq_cmp: WIDTH must be a multiple of SLICE");
   end

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              eq_q, eq_d;
   logic              gt_q, gt_d;
   logic [SUW-1:0]    su_q, su_d;

   logic [WIDTH-1:0]  a_sh, b_sh;
   logic [SLICE-1:0]  sa, sb;
   logic              slice_eq, slice_gt;
   logic              flip;

`ifdef SEQ_CMP_SIGNED_EN
   logic              smode_q;

   // Capture the signedness of the operation together with its operands.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         smode_q <= 1'b0;
      end else if (state_q == IDLE && in_valid) begin
         smode_q <= signed_mode;
      end
   end

   // Two's complement order equals unsigned order once both sign bits are
   // inverted, and the sign bit only lives in the top slice.
   assign flip = smode_q && (idx_q == IDX_TOP);
`else
   assign flip = 1'b0;
`endif

   // Select the current slice of each registered operand.
   always_comb begin
      a_sh = a_q >> (SLICE * idx_q);
      b_sh = b_q >> (SLICE * idx_q);
      sa   = a_sh[SLICE-1:0];
      sb   = b_sh[SLICE-1:0];
      sa[SLICE-1] = sa[SLICE-1] ^ flip;
      sb[SLICE-1] = sb[SLICE-1] ^ flip;
   end

   cmp_slice #(
      .SLICE (SLICE)
   ) u_cmp_slice (
      .a  (sa),
      .b  (sb),
      .eq (slice_eq),
      .gt (slice_gt)
   );

   // State, operand and result registers; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         su_q    <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         su_q    <= su_d;
      end
   end

   // Next-state logic: accept, walk slices MSB-first, hold result until taken.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      su_d    = su_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               idx_d   = IDX_TOP;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!slice_eq) begin
               gt_d    = slice_gt;
               eq_d    = 1'b0;
               su_d    = SUW'(NSLICE) - SUW'(idx_q);
               state_d = DONE;
            end else if (idx_q == '0) begin
               gt_d    = 1'b0;
               eq_d    = 1'b1;
               su_d    = SUW'(NSLICE);
               state_d = DONE;
            end else begin
               idx_d   = idx_q - IDXW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign equal       = eq_q;
   assign greater     = gt_q;
   assign answer      = gt_q | eq_q;
   assign slices_used = su_q;

endmodule

// File: tb/tb_seq_cmp.sv
// Self-checking bench for seq_cmp (WIDTH=16, SLICE=2). Directed corner
// cases plus randomized operands, scored against an arithmetic model.
module tb_seq_cmp;

   localparam int WIDTH  = 16;
   localparam int SLICE  = 2;
   localparam int NSLICE = WIDTH / SLICE;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              out_valid;
   logic              out_ready;
   logic              equal;
   logic              greater;
   logic              answer;
   logic [3:0]        slices_used;
`ifdef SEQ_CMP_SIGNED_EN
   logic              signed_mode;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   seq_cmp #(
      .WIDTH (WIDTH),
      .SLICE (SLICE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef SEQ_CMP_SIGNED_EN
      .signed_mode (signed_mode),
`endif
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .equal       (equal),
      .greater     (greater),
      .answer      (answer),
      .slices_used (slices_used)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: ordering from integer compare; slices examined = slices down
   // to and including the one holding the highest differing bit.
   function automatic void model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input bit sm, output bit eq, output bit gt, output int su);
      logic [WIDTH-1:0] x;
      int top;
      x   = ma ^ mb;
      eq  = (x == '0);
      top = -1;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (x[i] && top < 0) top = i;
      end
      su = eq ? NSLICE : NSLICE - top / SLICE;
      gt = sm ? ($signed(ma) > $signed(mb)) : (ma > mb);
   endfunction

   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input bit sm, input int hold);
      bit eq, gt;
      int su, cnt;
      model(ta, tb_v, sm, eq, gt, su);
      check("idle_in_ready", in_ready, 1);
      a        = ta;
      b        = tb_v;
`ifdef SEQ_CMP_SIGNED_EN
      signed_mode = sm;
`endif
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      check("run_in_ready", in_ready, 0);
      cnt = 0;
      while (!out_valid && cnt < NSLICE + 4) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("latency", cnt, su);
      check("equal", equal, eq);
      check("greater", greater, gt);
      check("answer", answer, eq | gt);
      check("slices_used", slices_used, su);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_out_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_equal", equal, eq);
         check("hold_greater", greater, gt);
         check("hold_slices", slices_used, su);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("taken_out_valid", out_valid, 0);
      check("taken_in_ready", in_ready, 1);
      check("kept_greater", greater, gt);
      check("kept_answer", answer, eq | gt);
      check("kept_slices", slices_used, su);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      bit sm;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
`ifdef SEQ_CMP_SIGNED_EN
      signed_mode = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_equal", equal, 0);
      check("rst_answer", answer, 0);
      check("rst_slices", slices_used, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed corners.
      run_op(16'h1234, 16'h1234, 1'b0, 0);
      run_op(16'h8000, 16'h7FFF, 1'b0, 0);
      run_op(16'h0001, 16'h0002, 1'b0, 0);
      run_op(16'hA5C3, 16'hA5C1, 1'b0, 5);
      run_op(16'h0000, 16'hFFFF, 1'b0, 1);
`ifdef SEQ_CMP_SIGNED_EN
      run_op(16'hFFFF, 16'h0001, 1'b1, 0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 0);
      run_op(16'h7FFF, 16'h8000, 1'b1, 0);
      run_op(16'hFFFE, 16'hFFFF, 1'b1, 0);
`endif

      // Randomized operands, biased toward long shared prefixes.
      for (int n = 0; n < 40; n++) begin
         ra = WIDTH'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
            2:       rb = ra ^ WIDTH'($urandom_range(0, 15));
            default: rb = WIDTH'($urandom);
         endcase
`ifdef SEQ_CMP_SIGNED_EN
         sm = bit'($urandom_range(0, 1));
`else
         sm = 1'b0;
`endif
         run_op(ra, rb, sm, $urandom_range(0, 3));
      end

      // Reset in the middle of a long operation discards it.
      a        = 16'h4321;
      b        = 16'h4321;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_equal", equal, 0);
      check("midrst_greater", greater, 0);
      check("midrst_answer", answer, 0);
      check("midrst_slices", slices_used, 0);
      for (int c = 0; c < NSLICE + 2; c++) begin
         @(posedge clk); #1;
         check("midrst_no_result", out_valid, 0);
      end

      // Bench still usable after reset.
      run_op(16'h0F00, 16'h0E00, 1'b0, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
